// File: rtl/uart_mem_bridge_pkg.sv
// uart_mem_bridge_pkg: command/response byte codes and FSM state encoding shared by the bridge files.
package uart_mem_bridge_pkg;
  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] RSP_ACK  = 8'h4B;
  localparam logic [7:0] RSP_ERR  = 8'h3F;
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ADDR    = 3'd1;
  localparam logic [2:0] S_DATA    = 3'd2;
  localparam logic [2:0] S_REQ     = 3'd3;
  localparam logic [2:0] S_WAIT_RD = 3'd4;
  localparam logic [2:0] S_ERR     = 3'd5;
  localparam logic [2:0] S_SEND    = 3'd6;
  localparam logic [2:0] S_GUARD   = 3'd7;
  function automatic logic [31:0] rsp_word(input logic [7:0] b);
    return {b, 24'h0};
  endfunction
endpackage

// File: rtl/uart_mem_bridge_byte_shift_tx.sv
// uart_mem_bridge_byte_shift_tx: 32-bit load register that hands out its bytes MSB first.
module uart_mem_bridge_byte_shift_tx
  import uart_mem_bridge_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic [31:0] i_data,
  input  logic [2:0]  i_cnt,
  input  logic        i_shift,
  output logic [7:0]  o_byte,
  output logic        o_more
);
  logic [31:0] r_data;
  logic [2:0]  r_cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data <= '0;
      r_cnt  <= '0;
    end else if (i_load) begin
      r_data <= i_data;
      r_cnt  <= i_cnt;
    end else if (i_shift) begin
      r_data <= {r_data[23:0], 8'h00};
      r_cnt  <= r_cnt - 3'd1;
    end
  end
  assign o_byte = r_data[31:24];
  assign o_more = r_cnt != 3'd0;
endmodule

// File: rtl/uart_mem_bridge.sv
// uart_mem_bridge: turns host UART command bytes into single 32-bit SDRAM read/write requests
// and returns an ack byte or the read word over the UART transmitter.
module uart_mem_bridge
  import uart_mem_bridge_pkg::*;
#(
  parameter int ADDR_W  = 23,
  parameter int TIMEOUT = 5_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        i_rx_data,
  input  logic              i_new_rx_data,
  output logic [7:0]        o_tx_data,
  output logic              o_new_tx_data,
  input  logic              i_tx_busy,
  output logic              o_mem_valid,
  input  logic              i_mem_ready,
  output logic              o_mem_write,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  input  logic [31:0]       i_mem_rdata,
  input  logic              i_mem_rdata_valid,
  output logic              o_busy
);
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [2:0]        r_state;
  logic [1:0]        r_bcnt;
  logic [TW-1:0]     r_tcnt;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              r_write;
  logic [7:0]        r_tx_data;
  logic              r_new_tx;
  logic              w_shift;
  logic              w_load;
  logic [31:0]       w_load_data;
  logic [2:0]        w_load_cnt;
  logic [7:0]        w_byte;
  logic              w_more;
  logic              w_tout;
  logic              w_last;
  logic              w_rd_ret;
  assign w_rd_ret    = r_state == S_WAIT_RD && i_mem_rdata_valid;
  assign w_shift     = r_state == S_SEND && !i_tx_busy;
  assign w_load      = (r_state == S_REQ && i_mem_ready && r_write) || w_rd_ret || r_state == S_ERR;
  assign w_load_data = w_rd_ret ? i_mem_rdata : rsp_word(r_state == S_ERR ? RSP_ERR : RSP_ACK);
  assign w_load_cnt  = w_rd_ret ? 3'd4 : 3'd1;
  assign w_tout      = r_tcnt == TW'(TIMEOUT);
  assign w_last      = r_bcnt == 2'd3;
  uart_mem_bridge_byte_shift_tx u_tx (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_load),
    .i_data (w_load_data),
    .i_cnt  (w_load_cnt),
    .i_shift(w_shift),
    .o_byte (w_byte),
    .o_more (w_more)
  );
  // Bytes are only consumed in IDLE/ADDR/DATA; every other state ignores i_new_rx_data.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_bcnt    <= '0;
      r_tcnt    <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_write   <= 1'b0;
      r_tx_data <= '0;
      r_new_tx  <= 1'b0;
    end else begin
      r_new_tx <= 1'b0;
      case (r_state)
        S_IDLE: if (i_new_rx_data) begin
          r_write <= i_rx_data == OP_WRITE;
          r_addr  <= '0;
          r_bcnt  <= '0;
          r_tcnt  <= '0;
          r_state <= (i_rx_data == OP_READ || i_rx_data == OP_WRITE) ? S_ADDR : S_ERR;
        end
        S_ADDR: if (i_new_rx_data) begin
          r_addr <= {r_addr[ADDR_W-9:0], i_rx_data};
          r_bcnt <= r_bcnt + 2'd1;
          r_tcnt <= '0;
          if (w_last) r_state <= r_write ? S_DATA : S_REQ;
        end else if (w_tout) begin
          r_state <= S_IDLE;
        end else begin
          r_tcnt <= r_tcnt + TW'(1);
        end
        S_DATA: if (i_new_rx_data) begin
          r_wdata <= {r_wdata[23:0], i_rx_data};
          r_bcnt  <= r_bcnt + 2'd1;
          r_tcnt  <= '0;
          if (w_last) r_state <= S_REQ;
        end else if (w_tout) begin
          r_state <= S_IDLE;
        end else begin
          r_tcnt <= r_tcnt + TW'(1);
        end
        S_REQ:     if (i_mem_ready) r_state <= r_write ? S_SEND : S_WAIT_RD;
        S_WAIT_RD: if (i_mem_rdata_valid) r_state <= S_SEND;
        S_ERR:     r_state <= S_SEND;
        S_SEND: if (!i_tx_busy) begin
          r_new_tx  <= 1'b1;
          r_tx_data <= w_byte;
          r_state   <= S_GUARD;
        end
        S_GUARD:   r_state <= w_more ? S_SEND : S_IDLE;
        default:   r_state <= S_IDLE;
      endcase
    end
  end
  assign o_tx_data     = r_tx_data;
  assign o_new_tx_data = r_new_tx;
  assign o_mem_valid   = r_state == S_REQ;
  assign o_mem_write   = r_write;
  assign o_mem_addr    = r_addr;
  assign o_mem_wdata   = r_wdata;
  assign o_busy        = r_state != S_IDLE;
endmodule

// File: tb/tb_uart_mem_bridge.sv
// tb_uart_mem_bridge: scoreboard bench; stimulus queues expected requests and tx bytes, monitors pop and compare.
module tb_uart_mem_bridge;
  localparam int AW = 23;
  localparam int TO = 60;
  typedef struct {
    logic          w;
    logic [AW-1:0] a;
    logic [31:0]   d;
    int            cyc;
  } req_t;
  logic          clk = 0;
  logic          rst = 1;
  logic [7:0]    rx_data = 0;
  logic          new_rx = 0;
  logic [7:0]    tx_data;
  logic          new_tx;
  logic          tx_busy = 0;
  logic          mem_valid;
  logic          mem_ready = 0;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata = 0;
  logic          mem_rdata_valid = 0;
  logic          busy;
  int n_vec = 0, n_err = 0;
  int cyc = 0, last_tx = -100, tx_cnt = 0, vcnt = 0;
  int rdy_lat = 0, rd_lat = 5, rd_cd = -1;
  logic          hold_busy = 0;
  logic [31:0]   rd_word = 0;
  logic [7:0]    tx_q[$];
  req_t          req_q[$];
  uart_mem_bridge #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .i_rx_data(rx_data), .i_new_rx_data(new_rx),
    .o_tx_data(tx_data), .o_new_tx_data(new_tx), .i_tx_busy(tx_busy),
    .o_mem_valid(mem_valid), .i_mem_ready(mem_ready), .o_mem_write(mem_write),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata),
    .i_mem_rdata_valid(mem_rdata_valid), .o_busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic bad(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s at cycle %0d", nm, cyc);
  endtask
  // Memory model and request monitor: ready after rdy_lat valid cycles, read data rd_lat cycles later.
  always @(negedge clk) begin
    cyc++;
    mem_rdata_valid = 0;
    if (rd_cd == 0) begin
      mem_rdata = rd_word;
      mem_rdata_valid = 1;
    end
    if (rd_cd >= 0) rd_cd--;
    if (mem_valid) begin
      mem_ready = vcnt >= rdy_lat;
      if (req_q.size() == 0) bad("unexpected mem request");
      else begin
        chk("mem_write", {31'b0, mem_write}, {31'b0, req_q[0].w});
        chk("mem_addr", {9'b0, mem_addr}, {9'b0, req_q[0].a});
        if (req_q[0].w) chk("mem_wdata", mem_wdata, req_q[0].d);
        if (mem_ready) begin
          chk("mem_valid cycles", vcnt + 1, req_q[0].cyc);
          if (!req_q[0].w) rd_cd = rd_lat;
          void'(req_q.pop_front());
        end
      end
      vcnt = mem_ready ? 0 : vcnt + 1;
    end else begin
      mem_ready = 0;
      vcnt = 0;
    end
  end
  // Transmitter model and tx monitor; tx_busy here is the value the DUT sampled at the last edge.
  always @(negedge clk) begin
    if (new_tx) begin
      if (tx_busy) bad("new_tx_data while tx_busy");
      if (cyc - last_tx < 2) bad("tx strobes too close");
      if (tx_q.size() == 0) bad("unexpected tx byte");
      else chk("tx_data", {24'b0, tx_data}, {24'b0, tx_q.pop_front()});
      last_tx = cyc;
      tx_cnt = 3;
    end else if (tx_cnt > 0) tx_cnt--;
    tx_busy = hold_busy || tx_cnt > 0;
  end
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    new_rx = 1;
    @(negedge clk);
    new_rx = 0;
  endtask
  task automatic send_rd(input logic [31:0] a);
    send_byte(8'h52);
    for (int i = 3; i >= 0; i--) send_byte(a[i*8 +: 8]);
  endtask
  task automatic send_wr(input logic [31:0] a, input logic [31:0] d);
    send_byte(8'h57);
    for (int i = 3; i >= 0; i--) send_byte(a[i*8 +: 8]);
    for (int i = 3; i >= 0; i--) send_byte(d[i*8 +: 8]);
  endtask
  task automatic push_rd(input logic [AW-1:0] a, input int c, input logic [31:0] w);
    req_q.push_back('{w: 1'b0, a: a, d: 32'h0, cyc: c});
    for (int i = 3; i >= 0; i--) tx_q.push_back(w[i*8 +: 8]);
    rd_word = w;
  endtask
  task automatic wait_done(input string nm);
    int i;
    for (i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (tx_q.size() == 0 && req_q.size() == 0 && !busy) break;
    end
    if (i == 3000) bad({nm, " completion timeout"});
    chk({nm, " busy after"}, {31'b0, busy}, 32'd0);
  endtask
  task automatic chk_reset(input string nm);
    chk({nm, " new_tx_data"}, {31'b0, new_tx}, 32'd0);
    chk({nm, " tx_data"}, {24'b0, tx_data}, 32'd0);
    chk({nm, " mem_valid"}, {31'b0, mem_valid}, 32'd0);
    chk({nm, " mem_write"}, {31'b0, mem_write}, 32'd0);
    chk({nm, " mem_addr"}, {9'b0, mem_addr}, 32'd0);
    chk({nm, " mem_wdata"}, mem_wdata, 32'd0);
    chk({nm, " busy"}, {31'b0, busy}, 32'd0);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk_reset("reset");
    rst = 0;
    // write, ready tied high: one valid cycle then 'K'
    rdy_lat = 0;
    req_q.push_back('{w: 1'b1, a: 23'h001234, d: 32'hDEADBEEF, cyc: 1});
    tx_q.push_back(8'h4B);
    send_wr(32'h00001234, 32'hDEADBEEF);
    chk("wr mem_valid after last byte", {31'b0, mem_valid}, 32'd1);
    wait_done("write");
    // read, ready 3 cycles late, data 5 cycles after accept
    rdy_lat = 3;
    rd_lat = 5;
    push_rd(23'h000010, 4, 32'hCAFEF00D);
    send_rd(32'h00000010);
    chk("rd mem_valid after last byte", {31'b0, mem_valid}, 32'd1);
    wait_done("read");
    // unknown opcode
    tx_q.push_back(8'h3F);
    send_byte(8'h41);
    wait_done("bad opcode");
    // inter-byte timeout, then a normal read
    send_byte(8'h57);
    send_byte(8'h00);
    send_byte(8'h01);
    repeat (TO - 10) @(negedge clk);
    chk("timeout still waiting", {31'b0, busy}, 32'd1);
    repeat (20) @(negedge clk);
    chk("timeout back to idle", {31'b0, busy}, 32'd0);
    rdy_lat = 0;
    push_rd(23'h000020, 1, 32'h12345678);
    send_rd(32'h00000020);
    wait_done("read after timeout");
    // tx back-pressure, upper address bits truncated
    hold_busy = 1;
    push_rd(23'h7FFFFF, 1, 32'hA55A00FF);
    send_rd(32'hFFFFFFFF);
    repeat (200) @(negedge clk);
    chk("bytes held while busy", tx_q.size(), 32'd4);
    hold_busy = 0;
    wait_done("back-pressure");
    // reset while waiting for read data; late data must not produce tx
    rd_lat = 20;
    req_q.push_back('{w: 1'b0, a: 23'h000001, d: 32'h0, cyc: 1});
    rd_word = 32'h0BADF00D;
    send_rd(32'h00000001);
    repeat (4) @(negedge clk);
    chk("in WAIT_RD busy", {31'b0, busy}, 32'd1);
    rst = 1;
    @(negedge clk);
    chk_reset("mid-request reset");
    rst = 0;
    repeat (40) @(negedge clk);
    chk("late rdata ignored busy", {31'b0, busy}, 32'd0);
    chk("late rdata no tx queued", tx_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
